// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: one side of an async FIFO pointer pair.
// Owns the local binary/Gray pointers, synchronises the remote Gray pointer,
// gates increments against full (IsWrite=1) or empty (IsWrite=0) and
// registers the status flag.
// Optional build macro ASYNC_FIFO_PTR_LEVEL_EN adds o_level / o_almost.
module fifo_ptr_ctrl #(
  parameter int PtrWidth     = 2,
  parameter int NSync        = 2,
  parameter int IsWrite      = 1,
  parameter int AlmostThresh = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_inc_req,
  input  logic [PtrWidth:0]   i_remote_gray_ptr,
  output logic                o_inc_ack,
  output logic [PtrWidth:0]   o_bin_ptr_comb,
  output logic [PtrWidth:0]   o_bin_ptr,
  output logic [PtrWidth:0]   o_gray_ptr,
  output logic [PtrWidth-1:0] o_addr,
  output logic                o_block
`ifdef ASYNC_FIFO_PTR_LEVEL_EN
  ,
  output logic [PtrWidth:0]   o_level,
  output logic                o_almost
`endif
);
  localparam int PW = PtrWidth;
  localparam logic [PW:0] One = (PW+1)'(1);
  // Inverting the top two Gray bits is the Gray image of "binary + Depth".
  localparam logic [PW:0] TopMask = (One << PW) | (One << (PW-1));
  localparam logic BlkRst = (IsWrite == 0);

  logic            r_rst_meta;
  logic            r_rst_sync;
  logic [NSync-1:0][PW:0] r_sync;
  logic [PW:0]     w_rsync;
  logic            w_inc_ack;
  logic [PW:0]     w_bin_d;
  logic [PW:0]     w_gray_d;
  logic            w_blk_d;

  // Reset bridge: assert asynchronously, release after two local edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  // Remote Gray pointer synchroniser chain.
  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) r_sync <= '0;
    else             r_sync <= {r_sync[NSync-2:0], i_remote_gray_ptr};
  end

  assign w_rsync   = r_sync[NSync-1];
  assign w_inc_ack = i_inc_req & ~o_block & r_rst_sync;
  assign w_bin_d   = o_bin_ptr + (PW+1)'(w_inc_ack);
  assign w_gray_d  = (w_bin_d >> 1) ^ w_bin_d;
  // Flags compare next-state local pointer against the current synced remote.
  assign w_blk_d   = (IsWrite != 0) ? (w_gray_d == (w_rsync ^ TopMask))
                                    : (w_gray_d == w_rsync);

  assign o_inc_ack      = w_inc_ack;
  assign o_bin_ptr_comb = w_bin_d;
  assign o_addr         = o_bin_ptr[PW-1:0];

  // Local pointer and block flag registers.
  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      o_bin_ptr  <= '0;
      o_gray_ptr <= '0;
      o_block    <= BlkRst;
    end else begin
      o_bin_ptr  <= w_bin_d;
      o_gray_ptr <= w_gray_d;
      o_block    <= w_blk_d;
    end
  end

`ifdef ASYNC_FIFO_PTR_LEVEL_EN
  localparam int Depth = 1 << PW;
  localparam logic [PW:0] AlmWrLim = (PW+1)'(Depth - AlmostThresh);
  localparam logic [PW:0] AlmRdLim = (PW+1)'(AlmostThresh);

  logic [PW:0] w_rbin;
  logic [PW:0] w_level_d;
  logic        w_alm_d;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= PW; i++) w_rbin[i] = ^(w_rsync >> i);
  end

  assign w_level_d = (IsWrite != 0) ? (w_bin_d - w_rbin) : (w_rbin - w_bin_d);
  assign w_alm_d   = (IsWrite != 0) ? (w_level_d >= AlmWrLim)
                                    : (w_level_d <= AlmRdLim);

  // Occupancy and almost-flag registers.
  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      o_level  <= '0;
      o_almost <= BlkRst;
    end else begin
      o_level  <= w_level_d;
      o_almost <= w_alm_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench: a write-side and a read-side instance, checked every cycle against
// an arithmetic occupancy model, plus directed literal scenarios.
module tb_fifo_ptr_ctrl;
  localparam int PW = 2, NS = 2, D = 4, M = 8, T = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          link = 1'b0;
  logic          req[2];
  logic [PW:0]   tb_rem[2];
  logic [PW:0]   rem[2];
  logic          ack[2];
  logic [PW:0]   bcomb[2];
  logic [PW:0]   bin[2];
  logic [PW:0]   gray[2];
  logic [PW-1:0] addr[2];
  logic          blk[2];
`ifdef ASYNC_FIFO_PTR_LEVEL_EN
  logic [PW:0]   lvl[2];
  logic          alm[2];
`endif

  assign rem[0] = link ? gray[1] : tb_rem[0];
  assign rem[1] = link ? gray[0] : tb_rem[1];

  fifo_ptr_ctrl #(.PtrWidth(PW), .NSync(NS), .IsWrite(1), .AlmostThresh(T)) u_wr (
    .clk(clk), .rst_n(rst_n), .i_inc_req(req[0]), .i_remote_gray_ptr(rem[0]),
    .o_inc_ack(ack[0]), .o_bin_ptr_comb(bcomb[0]), .o_bin_ptr(bin[0]),
    .o_gray_ptr(gray[0]), .o_addr(addr[0]), .o_block(blk[0])
`ifdef ASYNC_FIFO_PTR_LEVEL_EN
    , .o_level(lvl[0]), .o_almost(alm[0])
`endif
  );

  fifo_ptr_ctrl #(.PtrWidth(PW), .NSync(NS), .IsWrite(0), .AlmostThresh(T)) u_rd (
    .clk(clk), .rst_n(rst_n), .i_inc_req(req[1]), .i_remote_gray_ptr(rem[1]),
    .o_inc_ack(ack[1]), .o_bin_ptr_comb(bcomb[1]), .o_bin_ptr(bin[1]),
    .o_gray_ptr(gray[1]), .o_addr(addr[1]), .o_block(blk[1])
`ifdef ASYNC_FIFO_PTR_LEVEL_EN
    , .o_level(lvl[1]), .o_almost(alm[1])
`endif
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input int side, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s side=%0d actual=%0d expected=%0d t=%0t", nm, side, act, exp, $time);
    end
  endtask

  function automatic int gr(input int b);
    return (b ^ (b >> 1)) % M;
  endfunction

  // Inverse Gray by search: the binary count whose Gray code matches.
  function automatic int g2b(input int g);
    for (int b = 0; b < M; b++) if (gr(b) == g) return b;
    return 0;
  endfunction

  // ---------------- behavioural model (side 0 = write, 1 = read) ----------
  int   m_bin[2];
  int   m_lvl[2];
  logic m_blk[2];
  logic m_alm[2];
  int   m_sync[2][NS];
  int   m_rs;

  task automatic mreset();
    m_rs = 0;
    for (int s = 0; s < 2; s++) begin
      m_bin[s] = 0; m_lvl[s] = 0;
      m_blk[s] = (s == 1); m_alm[s] = (s == 1);
      for (int i = 0; i < NS; i++) m_sync[s][i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mreset();
    else if (m_rs < 2) m_rs++;
    else begin
      for (int s = 0; s < 2; s++) begin
        int rb, bd, ak, df;
        rb = g2b(m_sync[s][NS-1]);
        ak = (req[s] && !m_blk[s]) ? 1 : 0;
        bd = (m_bin[s] + ak) % M;
        if (s == 0) begin
          df = (bd - rb + M) % M;
          m_blk[s] = (df == D);
          m_alm[s] = (df >= D - T);
        end else begin
          df = (rb - bd + M) % M;
          m_blk[s] = (df == 0);
          m_alm[s] = (df <= T);
        end
        m_lvl[s] = df;
        m_bin[s] = bd;
        for (int i = NS - 1; i > 0; i--) m_sync[s][i] = m_sync[s][i-1];
        m_sync[s][0] = rem[s];
      end
    end
  end

  // Compare every output of both sides against the model, away from the edge.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      int ea;
      ea = (req[s] && !m_blk[s] && m_rs == 2) ? 1 : 0;
      chk("ack", s, ack[s], ea);
      chk("bin_comb", s, bcomb[s], (m_bin[s] + ea) % M);
      chk("bin", s, bin[s], m_bin[s]);
      chk("gray", s, gray[s], gr(m_bin[s]));
      chk("addr", s, addr[s], m_bin[s] % D);
      chk("block", s, blk[s], m_blk[s]);
`ifdef ASYNC_FIFO_PTR_LEVEL_EN
      chk("level", s, lvl[s], m_lvl[s]);
      chk("almost", s, alm[s], m_alm[s]);
`endif
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  int g_exp[4] = '{1, 3, 2, 6};
  int prev;

  initial begin
    mreset();
    req[0] = 1'b0; req[1] = 1'b0;
    tb_rem[0] = '0; tb_rem[1] = '0;
    repeat (2) step();

    // Reset release, read side: empty and no ack during the sync window.
    req[1] = 1'b1;
    rst_n  = 1'b1;
    step();
    chk("s1_ack_e1", 1, ack[1], 0);
    chk("s1_blk_e1", 1, blk[1], 1);
    chk("s1_gray_e1", 1, gray[1], 0);
    step();
    chk("s1_ack_empty", 1, ack[1], 0);
    chk("s1_blk", 1, blk[1], 1);
    req[1] = 1'b0;

    // Fill write side to full with remote held at 0.
    req[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("s2_bin", 0, bin[0], k);
      chk("s2_gray", 0, gray[0], g_exp[k-1]);
    end
    chk("s2_full", 0, blk[0], 1);
    chk("s2_ack5", 0, ack[0], 0);
    step();
    chk("s2_bin_hold", 0, bin[0], 4);
    req[0] = 1'b0;

    // Full release after remote moves to Gray 1.
    tb_rem[0] = 3'd1;
    step(); chk("s3_blk_e1", 0, blk[0], 1);
    step(); chk("s3_blk_e2", 0, blk[0], 1);
    step(); chk("s3_blk_e3", 0, blk[0], 0);
`ifdef ASYNC_FIFO_PTR_LEVEL_EN
    chk("s3_level", 0, lvl[0], 3);
`endif

    // Wrap through 7 -> 0 with remote one behind; each Gray step is 1 bit.
    tb_rem[0] = 3'(gr(3));
    for (int k = 0; k < 4; k++) begin
      repeat (3) step();
      prev = gray[0];
      req[0] = 1'b1;
      step();
      req[0] = 1'b0;
      chk("s4_gray_1bit", 0, $countones(3'(prev) ^ gray[0]), 1);
      tb_rem[0] = 3'(gr((int'(bin[0]) + M - 1) % M));
    end
    chk("s4_bin_wrap", 0, bin[0], 0);
    chk("s4_gray_wrap", 0, gray[0], 0);

    // Restart, three pushes against an empty remote.
    rst_n = 1'b0;
    tb_rem[0] = '0;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    req[0] = 1'b1;
    repeat (3) step();
    req[0] = 1'b0;
    chk("s5_bin", 0, bin[0], 3);
    chk("s5_blk", 0, blk[0], 0);
`ifdef ASYNC_FIFO_PTR_LEVEL_EN
    chk("s5_level", 0, lvl[0], 3);
    chk("s5_almost", 0, alm[0], 1);
`endif

    // Mid-operation reset between edges: outputs clear with no clock.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("s6_bin", 0, bin[0], 0);
    chk("s6_gray", 0, gray[0], 0);
    chk("s6_blk_wr", 0, blk[0], 0);
    chk("s6_blk_rd", 1, blk[1], 1);

    // Randomised traffic with the two sides cross-connected.
    link = 1'b1;
    step();
    rst_n = 1'b1;
    for (int ph = 0; ph < 8; ph++) begin
      int bw, br;
      bw = $urandom_range(10, 95);
      br = $urandom_range(10, 95);
      for (int c = 0; c < 100; c++) begin
        step();
        req[0] = ($urandom_range(0, 99) < bw);
        req[1] = ($urandom_range(0, 99) < br);
        if (ph == 5 && c == 50) begin
          #2 rst_n = 1'b0;
          #1 rst_n = 1'b1;
        end
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
